// File: rtl/lzc_norm_pipe.sv
// Two-stage leading zero/one counter and left normalizer with valid/ready flow control.
// Optional performance counters are enabled by defining LZC_PERF_CNT_EN.
module lzc_norm_pipe #(
   parameter int WI_SZ  = 32,
   parameter int WO_SZ  = $clog2(WI_SZ) + 1,
   parameter int TAG_SZ = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WI_SZ-1:0]  in_data,
   input  logic              in_mode,
   input  logic [TAG_SZ-1:0] in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WO_SZ-1:0]  out_lzc,
   output logic [WI_SZ-1:0]  out_norm,
   output logic              out_zero,
   output logic [TAG_SZ-1:0] out_tag
`ifdef LZC_PERF_CNT_EN
  ,input  logic              perf_clr,
   output logic [15:0]       perf_in_cnt,
   output logic [15:0]       perf_zero_cnt
`endif
);

   localparam int LVL = $clog2(WI_SZ);
   localparam int PW  = 1 << LVL;

   logic [WI_SZ-1:0]  srcWord;
   logic [PW-1:0]     padWord;
   logic [WO_SZ-1:0]  lzcCount_d;
   logic [WI_SZ-1:0]  s2Norm_d;
   logic              s1Adv;
   logic              s2Adv;

   logic              s1Valid_q;
   logic [WI_SZ-1:0]  s1Data_q;
   logic [TAG_SZ-1:0] s1Tag_q;
   logic [WO_SZ-1:0]  s1Count_q;

   logic              s2Valid_q;
   logic [WI_SZ-1:0]  s2Norm_q;
   logic [WO_SZ-1:0]  s2Count_q;
   logic              s2Zero_q;
   logic [TAG_SZ-1:0] s2Tag_q;

   // Leading ones become leading zeros after inversion; padding bits terminate the count at WI_SZ.
   assign srcWord = in_mode ? ~in_data : in_data;

   generate
      if (PW > WI_SZ) begin : g_pad
         assign padWord = {srcWord, {(PW-WI_SZ){1'b1}}};
      end else begin : g_nopad
         assign padWord = srcWord;
      end
   endgenerate

   // Halving search: each level tests the top half of the remaining window and shifts it away if empty.
   always_comb begin
      logic [PW-1:0]    win;
      logic [WO_SZ-1:0] acc;
      win = padWord;
      acc = '0;
      for (int k = LVL - 1; k >= 0; k--) begin
         if ((win & ~({PW{1'b1}} >> (1 << k))) == '0) begin
            acc = acc + (WO_SZ'(1) << k);
            win = win << (1 << k);
         end
      end
      if (!win[PW-1]) begin
         acc = acc + WO_SZ'(1);
      end
      lzcCount_d = (acc > WO_SZ'(WI_SZ)) ? WO_SZ'(WI_SZ) : acc;
   end

   assign s2Norm_d = s1Data_q << s1Count_q;

   assign s2Adv    = !s2Valid_q || out_ready;
   assign s1Adv    = !s1Valid_q || s2Adv;
   assign in_ready = s1Adv;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1Valid_q <= 1'b0;
         s1Data_q  <= '0;
         s1Tag_q   <= '0;
         s1Count_q <= '0;
      end else if (s1Adv) begin
         s1Valid_q <= in_valid;
         if (in_valid) begin
            s1Data_q  <= in_data;
            s1Tag_q   <= in_tag;
            s1Count_q <= lzcCount_d;
         end
      end
   end

   // Output registers only change on a real transfer, so they hold steady under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2Valid_q <= 1'b0;
         s2Norm_q  <= '0;
         s2Count_q <= '0;
         s2Zero_q  <= 1'b0;
         s2Tag_q   <= '0;
      end else if (s2Adv) begin
         s2Valid_q <= s1Valid_q;
         if (s1Valid_q) begin
            s2Norm_q  <= s2Norm_d;
            s2Count_q <= s1Count_q;
            s2Zero_q  <= (s1Count_q == WO_SZ'(WI_SZ));
            s2Tag_q   <= s1Tag_q;
         end
      end
   end

   assign out_valid = s2Valid_q;
   assign out_lzc   = s2Count_q;
   assign out_norm  = s2Norm_q;
   assign out_zero  = s2Zero_q;
   assign out_tag   = s2Tag_q;

`ifdef LZC_PERF_CNT_EN
   logic [15:0] perfIn_q;
   logic [15:0] perfZero_q;

   always_ff @(posedge clk) begin
      if (rst || perf_clr) begin
         perfIn_q   <= '0;
         perfZero_q <= '0;
      end else begin
         if (in_valid && s1Adv && (perfIn_q != 16'hFFFF)) begin
            perfIn_q <= perfIn_q + 16'd1;
         end
         if (s2Valid_q && out_ready && s2Zero_q && (perfZero_q != 16'hFFFF)) begin
            perfZero_q <= perfZero_q + 16'd1;
         end
      end
   end

   assign perf_in_cnt   = perfIn_q;
   assign perf_zero_cnt = perfZero_q;
`endif

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Testbench for lzc_norm_pipe: fixed vectors, backpressure/reset sequences, a 24-bit instance
// and randomized traffic checked against a direct bit-scan reference model.
module tb_lzc_norm_pipe;

   localparam int WI = 32;
   localparam int WO = 6;
   localparam int TG = 4;

   typedef struct {
      logic [WI-1:0] data;
      logic          mode;
      logic [TG-1:0] tag;
      logic [WO-1:0] lzc;
      logic [WI-1:0] norm;
      logic          zero;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [WI-1:0] in_data;
   logic          in_mode;
   logic [TG-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [WO-1:0] out_lzc;
   logic [WI-1:0] out_norm;
   logic          out_zero;
   logic [TG-1:0] out_tag;

   logic          in_valid24;
   logic          in_ready24;
   logic [23:0]   in_data24;
   logic          in_mode24;
   logic [TG-1:0] in_tag24;
   logic          out_valid24;
   logic          out_ready24;
   logic [5:0]    out_lzc24;
   logic [23:0]   out_norm24;
   logic          out_zero24;
   logic [TG-1:0] out_tag24;

`ifdef LZC_PERF_CNT_EN
   logic          perf_clr;
   logic [15:0]   perf_in_cnt;
   logic [15:0]   perf_zero_cnt;
   logic [15:0]   perf_in_cnt24;
   logic [15:0]   perf_zero_cnt24;
`endif

   vec_t expQ[$];
   vec_t curExp;
   vec_t tab[11];
   int   vecCount  = 0;
   int   missCount = 0;

   logic          stallPrev = 1'b0;
   logic [WO-1:0] holdLzc;
   logic [WI-1:0] holdNorm;
   logic          holdZero;
   logic [TG-1:0] holdTag;

   always #5 clk = ~clk;

   lzc_norm_pipe #(.WI_SZ(WI), .WO_SZ(WO), .TAG_SZ(TG)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_lzc(out_lzc),
      .out_norm(out_norm), .out_zero(out_zero), .out_tag(out_tag)
`ifdef LZC_PERF_CNT_EN
     ,.perf_clr(perf_clr), .perf_in_cnt(perf_in_cnt), .perf_zero_cnt(perf_zero_cnt)
`endif
   );

   lzc_norm_pipe #(.WI_SZ(24), .WO_SZ(6), .TAG_SZ(TG)) dut24 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid24), .in_ready(in_ready24), .in_data(in_data24),
      .in_mode(in_mode24), .in_tag(in_tag24),
      .out_valid(out_valid24), .out_ready(out_ready24), .out_lzc(out_lzc24),
      .out_norm(out_norm24), .out_zero(out_zero24), .out_tag(out_tag24)
`ifdef LZC_PERF_CNT_EN
     ,.perf_clr(perf_clr), .perf_in_cnt(perf_in_cnt24), .perf_zero_cnt(perf_zero_cnt24)
`endif
   );

   // Reference: scan from the MSB while bits equal the mode bit.
   function automatic vec_t model(input logic [WI-1:0] d, input logic m, input logic [TG-1:0] t);
      vec_t r;
      int   c = 0;
      while (c < WI && d[WI-1-c] == m) c++;
      r.data = d;
      r.mode = m;
      r.tag  = t;
      r.lzc  = WO'(c);
      r.norm = (c == WI) ? '0 : (d << c);
      r.zero = (c == WI);
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: inputs and outputs are stable at the falling edge, so handshakes are decided here.
   always @(negedge clk) begin
      if (rst) begin
         expQ.delete();
         stallPrev = 1'b0;
      end else begin
         if (stallPrev) begin
            vecCount++;
            if (!out_valid || out_lzc !== holdLzc || out_norm !== holdNorm ||
                out_zero !== holdZero || out_tag !== holdTag) begin
               missCount++;
               $display("[TB] FAIL stall hold: got v=%0b lzc=%0d norm=%h tag=%0d, expected lzc=%0d norm=%h tag=%0d",
                        out_valid, out_lzc, out_norm, out_tag, holdLzc, holdNorm, holdTag);
            end
         end
         if (out_valid && out_ready) begin
            vecCount++;
            if (expQ.size() == 0) begin
               missCount++;
               $display("[TB] FAIL unexpected output: got lzc=%0d norm=%h tag=%0d, expected none",
                        out_lzc, out_norm, out_tag);
            end else begin
               vec_t e;
               e = expQ.pop_front();
               if (out_lzc !== e.lzc || out_norm !== e.norm || out_zero !== e.zero || out_tag !== e.tag) begin
                  missCount++;
                  $display("[TB] FAIL result data=%h mode=%0b: got lzc=%0d norm=%h zero=%0b tag=%0d, expected lzc=%0d norm=%h zero=%0b tag=%0d",
                           e.data, e.mode, out_lzc, out_norm, out_zero, out_tag, e.lzc, e.norm, e.zero, e.tag);
               end
            end
         end
         stallPrev = out_valid && !out_ready;
         holdLzc   = out_lzc;
         holdNorm  = out_norm;
         holdZero  = out_zero;
         holdTag   = out_tag;
         if (in_valid && in_ready) expQ.push_back(curExp);
      end
   end

   // Presents one word and holds it until accepted; returns just after the accepting edge.
   task automatic applyStimulus(input vec_t v);
      int n = 0;
      curExp   = v;
      in_valid = 1'b1;
      in_data  = v.data;
      in_mode  = v.mode;
      in_tag   = v.tag;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL accept timeout: got in_ready=0, expected 1 within 200 cycles");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drainPipe();
      int n = 0;
      out_ready = 1'b1;
      while (expQ.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", 64'(expQ.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic run24(input logic [23:0] d, input logic m, input logic [TG-1:0] t,
                        input logic [5:0] eL, input logic [23:0] eN, input logic eZ);
      in_valid24 = 1'b1;
      in_data24  = d;
      in_mode24  = m;
      in_tag24   = t;
      @(negedge clk);
      checkOutput("w24 in_ready", 64'(in_ready24), 64'd1);
      @(posedge clk);
      #1;
      in_valid24 = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("w24 out_valid", 64'(out_valid24), 64'd1);
      checkOutput("w24 lzc", 64'(out_lzc24), 64'(eL));
      checkOutput("w24 norm", 64'(out_norm24), 64'(eN));
      checkOutput("w24 zero", 64'(out_zero24), 64'(eZ));
      checkOutput("w24 tag", 64'(out_tag24), 64'(t));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        bad;
      logic        acc;
      logic [TG-1:0] tagCnt;
      logic [WI-1:0] rd;
      logic          rm;

      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_tag = '0; out_ready = 1'b1;
      in_valid24 = 1'b0; in_data24 = '0; in_mode24 = 1'b0; in_tag24 = '0; out_ready24 = 1'b1;
`ifdef LZC_PERF_CNT_EN
      perf_clr = 1'b0;
`endif
      tab[0]  = '{32'h0001_0000, 1'b0, 4'd0,  6'd15, 32'h8000_0000, 1'b0};
      tab[1]  = '{32'h0000_0000, 1'b0, 4'd1,  6'd32, 32'h0000_0000, 1'b1};
      tab[2]  = '{32'hFFFF_FFFF, 1'b1, 4'd2,  6'd32, 32'h0000_0000, 1'b1};
      tab[3]  = '{32'hF0F0_0000, 1'b1, 4'd3,  6'd4,  32'h0F00_0000, 1'b0};
      tab[4]  = '{32'h8000_0000, 1'b0, 4'd4,  6'd0,  32'h8000_0000, 1'b0};
      tab[5]  = '{32'h0000_0001, 1'b0, 4'd5,  6'd31, 32'h8000_0000, 1'b0};
      tab[6]  = '{32'h7FFF_FFFF, 1'b1, 4'd6,  6'd0,  32'h7FFF_FFFF, 1'b0};
      tab[7]  = '{32'hFFFF_FFFE, 1'b1, 4'd7,  6'd31, 32'h0000_0000, 1'b0};
      tab[8]  = '{32'hFFFF_FFFF, 1'b0, 4'd8,  6'd0,  32'hFFFF_FFFF, 1'b0};
      tab[9]  = '{32'h0000_0000, 1'b1, 4'd9,  6'd0,  32'h0000_0000, 1'b0};
      tab[10] = '{32'h0000_4321, 1'b0, 4'd10, 6'd17, 32'h8642_0000, 1'b0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset out_lzc", 64'(out_lzc), 64'd0);
      checkOutput("reset out_norm", 64'(out_norm), 64'd0);
      checkOutput("reset out_zero", 64'(out_zero), 64'd0);
      checkOutput("reset out_tag", 64'(out_tag), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("in_ready after reset", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Latency: a word presented in one cycle appears two edges later.
      curExp = tab[0];
      in_valid = 1'b1; in_data = tab[0].data; in_mode = tab[0].mode; in_tag = tab[0].tag;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("latency edge1 valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("latency edge2 valid", 64'(out_valid), 64'd1);
      checkOutput("latency lzc", 64'(out_lzc), 64'd15);
      checkOutput("latency norm", 64'(out_norm), 64'h8000_0000);
      drainPipe();

      for (int i = 0; i < 11; i++) applyStimulus(tab[i]);
      drainPipe();

      // Backpressure: two words fill the pipe, the third waits until out_ready returns.
      out_ready = 1'b0;
      applyStimulus(model(32'h0000_00F0, 1'b0, 4'd0));
      applyStimulus(model(32'h00F0_0000, 1'b0, 4'd1));
      curExp = model(32'hFFF0_0000, 1'b1, 4'd2);
      in_valid = 1'b1; in_data = 32'hFFF0_0000; in_mode = 1'b1; in_tag = 4'd2;
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (in_ready) bad = 1'b1;
      end
      checkOutput("full in_ready low", 64'(bad), 64'd0);
      checkOutput("full out_tag", 64'(out_tag), 64'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      applyStimulus(curExp);
      drainPipe();

      // Reset with two words in flight discards both.
      out_ready = 1'b0;
      applyStimulus(model(32'h0000_0100, 1'b0, 4'd5));
      applyStimulus(model(32'h0000_0200, 1'b0, 4'd6));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst flush out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst flush in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      bad = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) bad = 1'b1;
      end
      checkOutput("no stale output", 64'(bad), 64'd0);
      @(posedge clk);
      #1;

      run24(24'h000001, 1'b0, 4'd3, 6'd23, 24'h800000, 1'b0);
      run24(24'h000000, 1'b0, 4'd4, 6'd24, 24'h000000, 1'b1);
      run24(24'hFFFFFF, 1'b1, 4'd5, 6'd24, 24'h000000, 1'b1);
      run24(24'hFF8000, 1'b1, 4'd6, 6'd9,  24'h000000, 1'b0);
      run24(24'h0003A5, 1'b0, 4'd7, 6'd14, 24'hE94000, 1'b0);

      // Random traffic with random backpressure; data biased toward long leading runs.
      tagCnt = '0;
      for (int c = 0; c < 1500; c++) begin
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            rd = WI'($urandom()) >> $urandom_range(0, WI);
            rm = 1'(($urandom() & 1));
            if (rm) rd = ~rd;
            curExp   = model(rd, rm, tagCnt);
            in_valid = 1'b1;
            in_data  = rd;
            in_mode  = rm;
            in_tag   = tagCnt;
            tagCnt   = tagCnt + 1'b1;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      drainPipe();

`ifdef LZC_PERF_CNT_EN
      perf_clr = 1'b1;
      @(posedge clk);
      #1;
      perf_clr = 1'b0;
      @(negedge clk);
      checkOutput("perf clr in", 64'(perf_in_cnt), 64'd0);
      checkOutput("perf clr zero", 64'(perf_zero_cnt), 64'd0);
      @(posedge clk);
      #1;
      applyStimulus(model(32'h0000_0000, 1'b0, 4'd1));
      applyStimulus(model(32'h0000_0010, 1'b0, 4'd2));
      drainPipe();
      checkOutput("perf in count", 64'(perf_in_cnt), 64'd2);
      checkOutput("perf zero count", 64'(perf_zero_cnt), 64'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
